// File: rtl/dw_conv_engine_pkg.sv
// Shared constants and packing helpers for the depthwise convolution path.
// The window generator, this engine and the result-BRAM writer import this
// package so that they agree on tap/channel packing and on pipeline latency.
//   CONV_LATENCY : enabled cycles from a sampled i_valid to the matching o_valid
//   K_SZ, PROD_W : tap count and product width for the default geometry
//   k_sz/prod_w  : the same quantities for any parameterisation
//   win_lsb      : LSB of tap 'tap' of channel 'ch' in a flat window/kernel bus
//   acc_lsb      : LSB of channel 'ch' in the flat result bus
package dw_conv_engine_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int K_DIM_DEF    = 3;
    localparam int K_SZ         = K_DIM_DEF * K_DIM_DEF;
    localparam int PROD_W       = 2 * DATA_W_DEF;
    localparam int CONV_LATENCY = 3;

    function automatic int k_sz(input int k_dim);
        return k_dim * k_dim;
    endfunction

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int win_lsb(input int ch, input int tap, input int k_dim, input int data_w);
        return (ch * k_dim * k_dim + tap) * data_w;
    endfunction

    function automatic int acc_lsb(input int ch, input int acc_w);
        return ch * acc_w;
    endfunction

endpackage

// File: rtl/dw_conv_engine_mac_channel.sv
// dw_mac_channel: one channel's K_SZ-tap multiply-accumulate, three register
// stages (products, row sums, total). Data registers only; the valid chain is
// kept by the parent so all channels share one copy.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all data registers)
//   clk_en     : stage advance enable; 0 holds every register
//   win        : K_SZ signed taps, tap t at [(t+1)*DATA_W-1 -: DATA_W]
//   kernel     : K_SZ signed taps, same packing as win
//   acc        : signed dot product, ACC_W bits, valid 3 enabled cycles later
module dw_mac_channel
    import dw_conv_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K_DIM  = 3,
    parameter int ACC_W  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clk_en,
    input  logic [K_DIM*K_DIM*DATA_W-1:0]     win,
    input  logic [K_DIM*K_DIM*DATA_W-1:0]     kernel,
    output logic [ACC_W-1:0]                  acc
);

    localparam int KS = k_sz(K_DIM);
    localparam int PW = prod_w(DATA_W);

    logic signed [PW-1:0]    prod_d [KS];
    logic signed [PW-1:0]    prod_q [KS];
    logic signed [ACC_W-1:0] row_d  [K_DIM];
    logic signed [ACC_W-1:0] row_q  [K_DIM];
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    // Operands are sign-extended to the product width before multiplying so
    // the product is exact for every pair, including -min * -min.
    always_comb begin
        for (int t = 0; t < KS; t++) begin
            prod_d[t] = PW'($signed(win[t*DATA_W +: DATA_W])) *
                        PW'($signed(kernel[t*DATA_W +: DATA_W]));
        end
    end

    // Row sums: products are sign-extended to ACC_W first, so no partial sum
    // can wrap given ACC_W >= 2*DATA_W + clog2(K_SZ).
    always_comb begin
        row_d = '{default: '0};
        for (int r = 0; r < K_DIM; r++) begin
            for (int k = 0; k < K_DIM; k++) begin
                row_d[r] = row_d[r] +
                    {{(ACC_W-PW){prod_q[r*K_DIM+k][PW-1]}}, prod_q[r*K_DIM+k]};
            end
        end
    end

    always_comb begin
        acc_d = '0;
        for (int r = 0; r < K_DIM; r++) begin
            acc_d = acc_d + row_q[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < KS; t++) prod_q[t] <= '0;
            for (int r = 0; r < K_DIM; r++) row_q[r] <= '0;
            acc_q <= '0;
        end else if (clk_en) begin
            for (int t = 0; t < KS; t++) prod_q[t] <= prod_d[t];
            for (int r = 0; r < K_DIM; r++) row_q[r] <= row_d[r];
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dw_conv_engine.sv
// dw_conv_engine: depthwise convolution responder. Each valid beat carries an
// IN_CH x K_DIM x K_DIM window and matching kernel; IN_CH independent dot
// products come back CONV_LATENCY enabled cycles later. Fully pipelined, no
// backpressure, one beat per enabled cycle.
// Handshake: i_valid is sampled only on cycles with i_clk_en=1; there is no
// ready, the source must hold a beat until an enabled cycle takes it.
// o_valid is high for exactly one enabled cycle per accepted beat, in order;
// o_acc_flat is meaningful only while o_valid=1.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (flushes in-flight beats)
//   i_clk_en       : shared clock enable; 0 freezes every register
//   i_valid        : beat valid
//   i_win_flat     : windows, channel c at [(c+1)*K_SZ*DATA_W-1 -: K_SZ*DATA_W]
//   i_kernel_flat  : kernels, same packing as i_win_flat
//   o_acc_flat     : results, channel c at [(c+1)*ACC_W-1 -: ACC_W]
//   o_valid        : result beat valid
//   o_busy         : a valid beat is somewhere in stages 1..3
module dw_conv_engine
    import dw_conv_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IN_CH  = 8,
    parameter int K_DIM  = 3,
    parameter int ACC_W  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_clk_en,
    input  logic                                  i_valid,
    input  logic [IN_CH*K_DIM*K_DIM*DATA_W-1:0]   i_win_flat,
    input  logic [IN_CH*K_DIM*K_DIM*DATA_W-1:0]   i_kernel_flat,
    output logic [IN_CH*ACC_W-1:0]                o_acc_flat,
    output logic                                  o_valid,
    output logic                                  o_busy
);

    localparam int KS      = k_sz(K_DIM);
    localparam int SLICE_W = KS * DATA_W;

    logic v1;
    logic v2;

    // Valid travels alongside the data stages; the data path itself is not
    // gated by valid, only this chain says which output beats are real.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_clk_en) begin
            v1      <= i_valid;
            v2      <= v1;
            o_valid <= v2;
        end
    end

    assign o_busy = v1 | v2 | o_valid;

    for (genvar c = 0; c < IN_CH; c++) begin : g_ch
        localparam int WL = win_lsb(c, 0, K_DIM, DATA_W);
        localparam int AL = acc_lsb(c, ACC_W);

        dw_mac_channel #(
            .DATA_W (DATA_W),
            .K_DIM  (K_DIM),
            .ACC_W  (ACC_W)
        ) u_mac (
            .clk    (clk),
            .rst_n  (rst_n),
            .clk_en (i_clk_en),
            .win    (i_win_flat[WL +: SLICE_W]),
            .kernel (i_kernel_flat[WL +: SLICE_W]),
            .acc    (o_acc_flat[AL +: ACC_W])
        );
    end

endmodule

// File: tb/tb_dw_conv_engine.sv
// Bench for dw_conv_engine: directed table of single beats, streamed beats
// with and without clock-enable gaps, and a mid-stream reset. A monitor keeps
// an expected queue of results with the enabled-cycle count each is due at.
module tb_dw_conv_engine;

    localparam int DATA_W = 8;
    localparam int IN_CH  = 8;
    localparam int K_DIM  = 3;
    localparam int ACC_W  = 32;
    localparam int K_SZ   = K_DIM * K_DIM;
    localparam int WIN_W  = IN_CH * K_SZ * DATA_W;
    localparam int OUT_W  = IN_CH * ACC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             i_clk_en = 1'b1;
    logic             i_valid = 1'b0;
    logic [WIN_W-1:0] i_win_flat = '0;
    logic [WIN_W-1:0] i_kernel_flat = '0;
    logic [OUT_W-1:0] o_acc_flat;
    logic             o_valid;
    logic             o_busy;

    dw_conv_engine #(
        .DATA_W (DATA_W),
        .IN_CH  (IN_CH),
        .K_DIM  (K_DIM),
        .ACC_W  (ACC_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clk_en      (i_clk_en),
        .i_valid       (i_valid),
        .i_win_flat    (i_win_flat),
        .i_kernel_flat (i_kernel_flat),
        .o_acc_flat    (o_acc_flat),
        .o_valid       (o_valid),
        .o_busy        (o_busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               due_q[$];
    int               en_cnt = 0;
    bit               out_live = 1'b0;
    bit               en_mode = 1'b0;
    logic [OUT_W-1:0] drv_exp = '0;
    logic [OUT_W-1:0] last_acc = '0;
    logic             last_valid = 1'b0;

    int wa [IN_CH][K_SZ];
    int ka [IN_CH][K_SZ];
    int ea [IN_CH];

    typedef struct {
        string            name;
        logic [WIN_W-1:0] win;
        logic [WIN_W-1:0] ker;
        logic [OUT_W-1:0] exp;
    } vec_t;

    vec_t vecs[3];

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIN_W-1:0] pack_taps(input bit use_kernel);
        logic [WIN_W-1:0] f;
        f = '0;
        for (int c = 0; c < IN_CH; c++)
            for (int t = 0; t < K_SZ; t++)
                f[(c*K_SZ+t)*DATA_W +: DATA_W] = use_kernel ? 8'(ka[c][t]) : 8'(wa[c][t]);
        return f;
    endfunction

    function automatic logic [OUT_W-1:0] pack_acc();
        logic [OUT_W-1:0] f;
        f = '0;
        for (int c = 0; c < IN_CH; c++) f[c*ACC_W +: ACC_W] = 32'(ea[c]);
        return f;
    endfunction

    // ---------------- monitor ----------------
    // A beat sampled on enabled edge k shows o_valid after enabled edge k+2,
    // i.e. it is on the output during the third enabled cycle after the one
    // that presented it.
    initial begin
        logic             en_e, v_e, r_e;
        logic [OUT_W-1:0] exp_e;
        bit               popped;
        forever begin
            @(posedge clk);
            en_e  = i_clk_en;
            v_e   = i_valid;
            r_e   = rst_n;
            exp_e = drv_exp;
            #1;
            if (r_e && rst_n) begin
                if (en_e) en_cnt++;
                if (en_e && v_e) begin
                    exp_q.push_back(exp_e);
                    due_q.push_back(en_cnt + 2);
                end
                if (!en_e) begin
                    chk("frozen_acc", o_acc_flat, last_acc);
                    chk("frozen_valid", OUT_W'(o_valid), OUT_W'(last_valid));
                end else begin
                    popped = 1'b0;
                    if (o_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("stray_valid", OUT_W'(1), OUT_W'(0));
                        end else begin
                            chk("result", o_acc_flat, exp_q.pop_front());
                            chk("latency", OUT_W'(en_cnt), OUT_W'(due_q.pop_front()));
                            popped = 1'b1;
                        end
                    end else if (due_q.size() != 0 && due_q[0] <= en_cnt) begin
                        chk("missing_valid", OUT_W'(0), OUT_W'(1));
                        void'(exp_q.pop_front());
                        void'(due_q.pop_front());
                    end
                    out_live = popped;
                end
                chk("busy", OUT_W'(o_busy), OUT_W'((exp_q.size() != 0) || out_live));
            end
            last_acc   = o_acc_flat;
            last_valid = o_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        i_clk_en = en_mode ? ~i_clk_en : 1'b1;
    endtask

    task automatic send(input logic [WIN_W-1:0] w, input logic [WIN_W-1:0] k,
                        input logic [OUT_W-1:0] e);
        logic en_now;
        i_valid       = 1'b1;
        i_win_flat    = w;
        i_kernel_flat = k;
        drv_exp       = e;
        do begin
            en_now = i_clk_en;
            tick();
        end while (!en_now);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_stream();
        for (int n = 0; n < 20; n++) begin
            for (int c = 0; c < IN_CH; c++) begin
                for (int t = 0; t < K_SZ; t++) begin
                    wa[c][t] = n;
                    ka[c][t] = c + 1;
                end
                ea[c] = 9 * n * (c + 1);
            end
            send(pack_taps(1'b0), pack_taps(1'b1), pack_acc());
        end
        i_valid = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // table: uniform 1x2, signed extremes, per-channel ramp
        for (int c = 0; c < IN_CH; c++) begin
            for (int t = 0; t < K_SZ; t++) begin wa[c][t] = 1; ka[c][t] = 2; end
            ea[c] = 18;
        end
        vecs[0] = '{name: "ones_x_twos", win: pack_taps(1'b0), ker: pack_taps(1'b1), exp: pack_acc()};

        for (int c = 0; c < IN_CH; c++) begin
            for (int t = 0; t < K_SZ; t++) begin
                case (c)
                    0:       begin wa[c][t] = -128; ka[c][t] = -128; end
                    1:       begin wa[c][t] = 127;  ka[c][t] = -128; end
                    2:       begin wa[c][t] = (t == 8) ? 0 : ((t % 2) ? -7 : 7); ka[c][t] = 3; end
                    default: begin wa[c][t] = c;    ka[c][t] = -c; end
                endcase
            end
        end
        ea[0] = 147456; ea[1] = -146304; ea[2] = 0;
        ea[3] = -81; ea[4] = -144; ea[5] = -225; ea[6] = -324; ea[7] = -441;
        vecs[1] = '{name: "extremes", win: pack_taps(1'b0), ker: pack_taps(1'b1), exp: pack_acc()};

        for (int c = 0; c < IN_CH; c++) begin
            for (int t = 0; t < K_SZ; t++) begin wa[c][t] = t + 1; ka[c][t] = c - 3; end
        end
        ea[0] = -135; ea[1] = -90; ea[2] = -45; ea[3] = 0;
        ea[4] = 45;   ea[5] = 90;  ea[6] = 135; ea[7] = 180;
        vecs[2] = '{name: "tap_ramp", win: pack_taps(1'b0), ker: pack_taps(1'b1), exp: pack_acc()};

        // reset
        #3 rst_n = 1'b0;
        #1;
        chk("reset_acc", o_acc_flat, '0);
        chk("reset_valid", OUT_W'(o_valid), OUT_W'(0));
        chk("reset_busy", OUT_W'(o_busy), OUT_W'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_acc", o_acc_flat, '0);
            chk("idle_valid", OUT_W'(o_valid), OUT_W'(0));
        end

        // directed single beats
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].win, vecs[i].ker, vecs[i].exp);
            idle(6);
        end

        // back-to-back stream, then with enable toggling every cycle
        run_stream();
        idle(5);
        en_mode = 1'b1;
        run_stream();
        idle(10);
        en_mode = 1'b0;
        idle(2);

        // reset with two beats in flight
        send(vecs[0].win, vecs[0].ker, vecs[0].exp);
        send(vecs[1].win, vecs[1].ker, vecs[1].exp);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("midrst_busy", OUT_W'(o_busy), OUT_W'(0));
        chk("midrst_valid", OUT_W'(o_valid), OUT_W'(0));
        chk("midrst_acc", o_acc_flat, '0);
        exp_q.delete();
        due_q.delete();
        out_live = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(4);
        send(vecs[2].win, vecs[2].ker, vecs[2].exp);
        idle(6);

        chk("drained", OUT_W'(exp_q.size()), OUT_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
